// File: rtl/simulation_result_sink_if.sv
// Valid/ready result-stream bundle from the accelerator output to the result sink.
interface simulation_result_sink_if #(
  parameter int DATA_WIDTH = 128
);
  logic [DATA_WIDTH-1:0] S_Data;
  logic                  S_Valid;
  logic                  S_Ready;

  modport master (output S_Data, output S_Valid, input S_Ready);
  modport slave  (input S_Data, input S_Valid, output S_Ready);
endinterface

// File: rtl/simulation_result_sink.sv
// Receive end of the result stream: captures each beat, checks it against a golden ROM,
// optionally throttles S_Ready, and raises done after RESULT_NUM beats.
module simulation_result_sink #(
  parameter int DATA_WIDTH    = 128,
  parameter int ADDR_WIDTH    = 21,
  parameter int RESULT_NUM    = 21632,
  parameter int STALL_PERIOD  = 0,
  parameter int ERR_CNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  simulation_result_sink_if.slave  s_if,
  output logic [ADDR_WIDTH-1:0]    gold_addr,
  input  logic [DATA_WIDTH-1:0]    gold_data,
  output logic                     cap_we,
  output logic [ADDR_WIDTH-1:0]    cap_addr,
  output logic [DATA_WIDTH-1:0]    cap_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err_flag,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]    first_err_addr
);
  localparam int SCW = (STALL_PERIOD > 2) ? $clog2(STALL_PERIOD) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_DRAIN, ST_DONE} state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [SCW-1:0]           r_stall_cnt;
  logic [ADDR_WIDTH-1:0]    r_beat_cnt;
  logic                     r_cap_we;
  logic [ADDR_WIDTH-1:0]    r_cap_addr;
  logic [DATA_WIDTH-1:0]    r_cap_data;
  logic                     r_done;
  logic                     r_err_flag;
  logic [ERR_CNT_WIDTH-1:0] r_err_cnt;
  logic [ADDR_WIDTH-1:0]    r_first_err;
  logic                     w_stall;
  logic                     w_accept;
  logic                     w_last;
  logic                     w_clear;
  logic                     w_mismatch;

  // Ready comes only from state, never from S_Valid.
  assign w_stall    = (STALL_PERIOD >= 2) && (r_stall_cnt == SCW'(STALL_PERIOD - 1));
  assign s_if.S_Ready = (r_state == ST_RECV) && !w_stall;
  assign w_accept   = s_if.S_Valid && s_if.S_Ready;
  assign w_last     = (r_beat_cnt == ADDR_WIDTH'(RESULT_NUM - 1));
  assign w_clear    = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_mismatch = r_cap_we && (r_cap_data != gold_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_RECV;
      ST_RECV:  if (w_accept && w_last) w_next = ST_DRAIN;
      ST_DRAIN: w_next = ST_DONE;
      ST_DONE:  if (start) w_next = ST_RECV;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_beat_cnt  <= '0;
      r_cap_we    <= 1'b0;
      r_cap_addr  <= '0;
      r_cap_data  <= '0;
      r_done      <= 1'b0;
      r_err_flag  <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else begin
      r_cap_we <= w_accept;
      if (w_accept) begin
        r_cap_addr <= r_beat_cnt;
        r_cap_data <= s_if.S_Data;
        r_beat_cnt <= r_beat_cnt + ADDR_WIDTH'(1);
      end
      if (w_clear) begin
        r_stall_cnt <= '0;
        r_beat_cnt  <= '0;
        r_done      <= 1'b0;
        r_err_flag  <= 1'b0;
        r_err_cnt   <= '0;
        r_first_err <= '0;
      end else begin
        // The compare runs one cycle behind capture, when the ROM data for that beat is out.
        if (w_mismatch) begin
          if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
          r_err_flag <= 1'b1;
          if (!r_err_flag) r_first_err <= r_cap_addr;
        end
        if (r_state == ST_DRAIN) r_done <= 1'b1;
        if ((STALL_PERIOD >= 2) && (r_state == ST_RECV))
          r_stall_cnt <= w_stall ? '0 : r_stall_cnt + SCW'(1);
      end
    end
  end

  assign gold_addr      = r_beat_cnt;
  assign cap_we         = r_cap_we;
  assign cap_addr       = r_cap_addr;
  assign cap_data       = r_cap_data;
  assign busy           = (r_state == ST_RECV) || (r_state == ST_DRAIN);
  assign done           = r_done;
  assign err_flag       = r_err_flag;
  assign err_cnt        = r_err_cnt;
  assign first_err_addr = r_first_err;
endmodule

// File: tb/tb_simulation_result_sink.sv
// Scoreboard bench: dut_a (4 beats, no stall) covers capture/compare/reset/start;
// dut_b (6 beats, stall period 3) covers the S_Ready throttle pattern.
module tb_simulation_result_sink;
  localparam int DW = 128;
  localparam int AW = 21;
  localparam int EW = 16;
  localparam int NA = 4;
  localparam int NB = 6;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  always #5 clk = ~clk;

  simulation_result_sink_if #(.DATA_WIDTH(DW)) ifa ();
  logic          start_a;
  logic [AW-1:0] gold_addr_a, cap_addr_a, first_err_a;
  logic [DW-1:0] gold_data_a, cap_data_a;
  logic          cap_we_a, busy_a, done_a, err_flag_a;
  logic [EW-1:0] err_cnt_a;
  logic [DW-1:0] stream_a [16];
  logic [DW-1:0] gold_a   [16];
  logic [DW-1:0] cap_a    [16];
  exp_t          sb_a [$];

  simulation_result_sink #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESULT_NUM(NA),
                           .STALL_PERIOD(0), .ERR_CNT_WIDTH(EW)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .s_if(ifa),
    .gold_addr(gold_addr_a), .gold_data(gold_data_a),
    .cap_we(cap_we_a), .cap_addr(cap_addr_a), .cap_data(cap_data_a),
    .busy(busy_a), .done(done_a), .err_flag(err_flag_a),
    .err_cnt(err_cnt_a), .first_err_addr(first_err_a));

  always @(posedge clk) gold_data_a <= gold_a[gold_addr_a[3:0]];
  always @(posedge clk) if (cap_we_a) cap_a[cap_addr_a[3:0]] <= cap_data_a;

  simulation_result_sink_if #(.DATA_WIDTH(DW)) ifb ();
  logic          start_b;
  logic [AW-1:0] gold_addr_b, cap_addr_b, first_err_b;
  logic [DW-1:0] gold_data_b, cap_data_b;
  logic          cap_we_b, busy_b, done_b, err_flag_b;
  logic [EW-1:0] err_cnt_b;
  logic [DW-1:0] stream_b [16];
  exp_t          sb_b [$];

  simulation_result_sink #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESULT_NUM(NB),
                           .STALL_PERIOD(3), .ERR_CNT_WIDTH(EW)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .s_if(ifb),
    .gold_addr(gold_addr_b), .gold_data(gold_data_b),
    .cap_we(cap_we_b), .cap_addr(cap_addr_b), .cap_data(cap_data_b),
    .busy(busy_b), .done(done_b), .err_flag(err_flag_b),
    .err_cnt(err_cnt_b), .first_err_addr(first_err_b));

  always @(posedge clk) gold_data_b <= stream_b[gold_addr_b[3:0]];

  function automatic logic [DW-1:0] rnd_beat();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic new_stream_a(input int mis0, input int mis1);
    for (int i = 0; i < 16; i++) begin
      stream_a[i] = rnd_beat();
      gold_a[i]   = stream_a[i];
      if (i == mis0 || i == mis1) gold_a[i] = stream_a[i] ^ {{(DW-1){1'b0}}, 1'b1};
    end
  endtask

  task automatic pulse_start_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int k = 0; k < 10 && !done_a; k++) @(negedge clk);
  endtask

  // Sends beats first..first+n-1 on dut_a; expected captures go through the scoreboard.
  task automatic run_a(input int first, input int n, input int pct, output int span);
    int sent, got, cyc, first_acc, last_acc;
    logic acc;
    exp_t e;
    sent = first; got = 0; cyc = 0; acc = 1'b0; first_acc = -1; last_acc = -1;
    while (got < n && cyc < 200) begin
      if (acc) sent++;
      ifa.S_Data  = stream_a[sent % 16];
      ifa.S_Valid = (sent < first + n) && ($urandom_range(99) < pct);
      acc = ifa.S_Valid && ifa.S_Ready;
      if (acc) begin
        e.addr = AW'(sent);
        e.data = stream_a[sent % 16];
        sb_a.push_back(e);
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      @(negedge clk); cyc++;
      if (cap_we_a) begin
        total++;
        if (sb_a.size() == 0) begin
          bad++; $display("FAIL cap_unexpected_a got addr=%0d want no write", cap_addr_a);
        end else begin
          e = sb_a.pop_front(); got++;
          if (cap_addr_a !== e.addr || cap_data_a !== e.data) begin
            bad++;
            $display("FAIL cap_beat_a got addr=%0d data=%h want addr=%0d data=%h",
                     cap_addr_a, cap_data_a, e.addr, e.data);
          end
        end
      end
    end
    ifa.S_Valid = 1'b0;
    total++;
    if (got != n) begin bad++; $display("FAIL run_a_beats got=%0d want=%0d", got, n); end
    span = last_acc - first_acc;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ifa.S_Valid = 1'b0; ifa.S_Data = '0; ifb.S_Valid = 1'b0; ifb.S_Data = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({ifa.S_Ready, cap_we_a, busy_a, done_a, err_flag_a} !== 5'b0) begin
      bad++; $display("FAIL reset_flags_a got=%b want=00000",
                      {ifa.S_Ready, cap_we_a, busy_a, done_a, err_flag_a});
    end
    total++;
    if (gold_addr_a !== '0 || cap_addr_a !== '0 || first_err_a !== '0) begin
      bad++; $display("FAIL reset_addr_a got gold=%0d cap=%0d first=%0d want 0",
                      gold_addr_a, cap_addr_a, first_err_a);
    end
    total++;
    if (cap_data_a !== '0 || err_cnt_a !== '0) begin
      bad++; $display("FAIL reset_data_a got data=%h cnt=%0d want 0", cap_data_a, err_cnt_a);
    end
    total++;
    if ({ifb.S_Ready, busy_b, done_b, cap_we_b} !== 4'b0) begin
      bad++; $display("FAIL reset_flags_b got=%b want=0000",
                      {ifb.S_Ready, busy_b, done_b, cap_we_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_match();
    int span;
    new_stream_a(-1, -1);
    pulse_start_a();
    run_a(0, NA, 100, span);
    total++;
    if (span !== NA - 1) begin bad++; $display("FAIL match_consecutive got span=%0d want=%0d", span, NA - 1); end
    total++;
    if (done_a !== 1'b0 || busy_a !== 1'b1) begin
      bad++; $display("FAIL match_drain got done=%b busy=%b want done=0 busy=1", done_a, busy_a);
    end
    @(negedge clk);
    total++;
    if (done_a !== 1'b1 || busy_a !== 1'b0) begin
      bad++; $display("FAIL match_done got done=%b busy=%b want done=1 busy=0", done_a, busy_a);
    end
    total++;
    if (err_cnt_a !== '0 || err_flag_a !== 1'b0 || gold_addr_a !== AW'(NA)) begin
      bad++; $display("FAIL match_errs got cnt=%0d flag=%b beats=%0d want 0 0 %0d",
                      err_cnt_a, err_flag_a, gold_addr_a, NA);
    end
  endtask

  task automatic test_mismatch();
    int span;
    new_stream_a(1, 3);
    pulse_start_a();
    total++;
    if (done_a !== 1'b0 || gold_addr_a !== '0) begin
      bad++; $display("FAIL mismatch_clear got done=%b beats=%0d want 0 0", done_a, gold_addr_a);
    end
    run_a(0, NA, 100, span);
    wait_done_a();
    total++;
    if (done_a !== 1'b1 || err_flag_a !== 1'b1 || err_cnt_a !== EW'(2) || first_err_a !== AW'(1)) begin
      bad++; $display("FAIL mismatch_errs got done=%b flag=%b cnt=%0d first=%0d want 1 1 2 1",
                      done_a, err_flag_a, err_cnt_a, first_err_a);
    end
  endtask

  task automatic test_stall();
    int sent, got, cyc, rc, first_acc, last_acc;
    logic acc, exp_rdy;
    exp_t e;
    for (int i = 0; i < 16; i++) stream_b[i] = rnd_beat();
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    sent = 0; got = 0; cyc = 0; rc = 0; acc = 1'b0; first_acc = -1; last_acc = -1;
    while (got < NB && cyc < 100) begin
      if (acc) sent++;
      ifb.S_Data  = stream_b[sent % 16];
      ifb.S_Valid = (sent < NB);
      if (sent < NB) begin
        exp_rdy = (rc % 3) != 2;
        rc++;
        total++;
        if (ifb.S_Ready !== exp_rdy) begin
          bad++; $display("FAIL stall_ready cycle=%0d got=%b want=%b", rc - 1, ifb.S_Ready, exp_rdy);
        end
      end
      acc = ifb.S_Valid && ifb.S_Ready;
      if (acc) begin
        e.addr = AW'(sent); e.data = stream_b[sent % 16];
        sb_b.push_back(e);
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
      end
      @(negedge clk); cyc++;
      if (cap_we_b) begin
        total++;
        if (sb_b.size() == 0) begin
          bad++; $display("FAIL stall_cap_unexpected got addr=%0d want no write", cap_addr_b);
        end else begin
          e = sb_b.pop_front(); got++;
          if (cap_addr_b !== e.addr || cap_data_b !== e.data) begin
            bad++; $display("FAIL stall_cap got addr=%0d want addr=%0d", cap_addr_b, e.addr);
          end
        end
      end
    end
    ifb.S_Valid = 1'b0;
    total++;
    if (got != NB || last_acc - first_acc != 7) begin
      bad++; $display("FAIL stall_span got beats=%0d span=%0d want beats=%0d span=7",
                      got, last_acc - first_acc, NB);
    end
    @(negedge clk);
    total++;
    if (done_b !== 1'b1 || err_cnt_b !== '0) begin
      bad++; $display("FAIL stall_done got done=%b cnt=%0d want 1 0", done_b, err_cnt_b);
    end
  endtask

  task automatic test_random_valid();
    int span;
    new_stream_a(-1, -1);
    ifa.S_Data = stream_a[0]; ifa.S_Valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      total++;
      if (ifa.S_Ready !== 1'b0 || cap_we_a !== 1'b0) begin
        bad++; $display("FAIL prestart_accept got ready=%b we=%b want 0 0", ifa.S_Ready, cap_we_a);
      end
    end
    pulse_start_a();
    run_a(0, NA, 50, span);
    wait_done_a();
    @(negedge clk);
    for (int i = 0; i < NA; i++) begin
      total++;
      if (cap_a[i] !== gold_a[i]) begin
        bad++; $display("FAIL capture_ram[%0d] got=%h want=%h", i, cap_a[i], gold_a[i]);
      end
    end
  endtask

  task automatic test_rst_midrun();
    int span;
    new_stream_a(0, -1);
    pulse_start_a();
    run_a(0, 2, 100, span);
    #2 rst = 1'b1;
    #1;
    total++;
    if ({ifa.S_Ready, busy_a, done_a, cap_we_a, err_flag_a} !== 5'b0 || err_cnt_a !== '0 ||
        gold_addr_a !== '0 || cap_addr_a !== '0 || cap_data_a !== '0) begin
      bad++; $display("FAIL rst_midrun_outputs got flags=%b cnt=%0d beats=%0d capaddr=%0d want all 0",
                      {ifa.S_Ready, busy_a, done_a, cap_we_a, err_flag_a}, err_cnt_a,
                      gold_addr_a, cap_addr_a);
    end
    @(negedge clk); rst = 1'b0;
    sb_a.delete();
    gold_a[0] = stream_a[0];
    pulse_start_a();
    run_a(0, NA, 100, span);
    wait_done_a();
    total++;
    if (done_a !== 1'b1 || err_cnt_a !== '0 || gold_addr_a !== AW'(NA)) begin
      bad++; $display("FAIL rst_rerun got done=%b cnt=%0d beats=%0d want 1 0 %0d",
                      done_a, err_cnt_a, gold_addr_a, NA);
    end
  endtask

  task automatic test_start_in_recv();
    int span;
    new_stream_a(0, -1);
    pulse_start_a();
    run_a(0, 2, 100, span);
    pulse_start_a();
    total++;
    if (busy_a !== 1'b1 || gold_addr_a !== AW'(2) || err_cnt_a !== EW'(1)) begin
      bad++; $display("FAIL start_in_recv got busy=%b beats=%0d cnt=%0d want 1 2 1",
                      busy_a, gold_addr_a, err_cnt_a);
    end
    run_a(2, 2, 100, span);
    wait_done_a();
    total++;
    if (done_a !== 1'b1 || err_cnt_a !== EW'(1) || first_err_a !== '0) begin
      bad++; $display("FAIL start_recv_done got done=%b cnt=%0d first=%0d want 1 1 0",
                      done_a, err_cnt_a, first_err_a);
    end
    gold_a[0] = stream_a[0];
    pulse_start_a();
    total++;
    if (done_a !== 1'b0 || err_cnt_a !== '0 || err_flag_a !== 1'b0 || busy_a !== 1'b1) begin
      bad++; $display("FAIL restart_clear got done=%b cnt=%0d flag=%b busy=%b want 0 0 0 1",
                      done_a, err_cnt_a, err_flag_a, busy_a);
    end
    run_a(0, NA, 100, span);
    wait_done_a();
    total++;
    if (done_a !== 1'b1 || err_cnt_a !== '0 || err_flag_a !== 1'b0) begin
      bad++; $display("FAIL second_run got done=%b cnt=%0d flag=%b want 1 0 0",
                      done_a, err_cnt_a, err_flag_a);
    end
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_stall();
    test_random_valid();
    test_rst_midrun();
    test_start_in_recv();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
